// File: rtl/uart_mem_loader.sv
// uart_mem_loader
//   Packet sequencer between a UART byte receiver and the SAD processor.
//   Parses the received byte stream into WRITE packets (header, address
//   high/low, length, data burst, XOR checksum) that are written to memory,
//   and single-byte RUN commands that start the processor and wait for it.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   rx_valid/rx_data  one-cycle byte strobe and byte from the UART receiver
//   mem_we/addr/wdata registered memory write port (one strobe per data byte)
//   proc_start        one-cycle processor start pulse
//   proc_done         processor completion strobe (honoured only while waiting)
//   busy              high whenever the sequencer is not idle
//   pkt_ok            one-cycle pulse when a WRITE packet checksum matches
//   err               sticky: [0] checksum, [1] timeout, [2] bad cmd / byte during run
//   clr_err           clears err; a new error in the same cycle still sets its bit
module uart_mem_loader #(
    parameter int          ADDR_WIDTH     = 16,
    parameter int          TIMEOUT_CYCLES = 500000,
    parameter logic [7:0]  CMD_WRITE      = 8'hA5,
    parameter logic [7:0]  CMD_RUN        = 8'h5A
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  proc_start,
    input  logic                  proc_done,
    output logic                  busy,
    output logic                  pkt_ok,
    output logic [2:0]            err,
    input  logic                  clr_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_AHI, S_ALO, S_LEN, S_DATA, S_CHK, S_START, S_WAIT_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           addr_q, addr_d;     // full 16-bit header address
    logic [8:0]            len_q, len_d;       // 1..256
    logic [8:0]            cnt_q, cnt_d;       // data bytes written so far
    logic [7:0]            chk_q, chk_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [2:0]            err_q, err_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [7:0]            wdata_q, wdata_d;
    logic                  start_q, start_d;
    logic                  ok_q, ok_d;
    logic                  in_pkt;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        chk_d   = chk_q;
        timer_d = '0;
        err_d   = clr_err ? 3'b000 : err_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        start_d = 1'b0;
        ok_d    = 1'b0;

        in_pkt = (state_q == S_AHI) || (state_q == S_ALO) || (state_q == S_LEN) ||
                 (state_q == S_DATA) || (state_q == S_CHK);

        // Inter-byte timer; a byte arriving on the expiry cycle takes priority.
        if (in_pkt && !rx_valid) begin
            if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d  = S_IDLE;
                err_d[1] = 1'b1;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_WRITE) begin
                        state_d = S_AHI;
                        chk_d   = 8'h00;
                    end else if (rx_data == CMD_RUN) begin
                        state_d = S_START;
                    end else begin
                        err_d[2] = 1'b1;
                    end
                end
            end
            S_AHI: begin
                if (rx_valid) begin
                    addr_d  = {rx_data, 8'h00};
                    chk_d   = chk_q ^ rx_data;
                    state_d = S_ALO;
                end
            end
            S_ALO: begin
                if (rx_valid) begin
                    addr_d  = {addr_q[15:8], rx_data};
                    chk_d   = chk_q ^ rx_data;
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (rx_valid) begin
                    len_d   = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                    cnt_d   = 9'd0;
                    chk_d   = chk_q ^ rx_data;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    we_d    = 1'b1;
                    // Truncation to ADDR_WIDTH gives the required address wrap.
                    waddr_d = addr_q[ADDR_WIDTH-1:0];
                    wdata_d = rx_data;
                    addr_d  = addr_q + 16'd1;
                    cnt_d   = cnt_q + 9'd1;
                    chk_d   = chk_q ^ rx_data;
                    if (cnt_q + 9'd1 == len_q) begin
                        state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (rx_valid) begin
                    if (rx_data == chk_q) begin
                        ok_d = 1'b1;
                    end else begin
                        err_d[0] = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                start_d = 1'b1;
                state_d = S_WAIT_DONE;
                if (rx_valid) begin
                    err_d[2] = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (rx_valid) begin
                    err_d[2] = 1'b1;
                end
                if (proc_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            chk_q   <= '0;
            timer_q <= '0;
            err_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            start_q <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            chk_q   <= chk_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            start_q <= start_d;
            ok_q    <= ok_d;
        end
    end

    assign mem_we     = we_q;
    assign mem_addr   = waddr_q;
    assign mem_wdata  = wdata_q;
    assign proc_start = start_q;
    assign pkt_ok     = ok_q;
    assign err        = err_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_mem_loader.sv
// Testbench for uart_mem_loader: a table of per-cycle vectors
// {inputs, expected registered outputs} plus hand-written sequences for
// the 256-byte burst, the inter-byte timeout and reset mid-packet.
module tb_uart_mem_loader;

    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        proc_start;
    logic        proc_done;
    logic        busy;
    logic        pkt_ok;
    logic [2:0]  err;
    logic        clr_err;

    int n_vec = 0;
    int n_bad = 0;

    uart_mem_loader #(
        .ADDR_WIDTH    (16),
        .TIMEOUT_CYCLES(TMO),
        .CMD_WRITE     (8'hA5),
        .CMD_RUN       (8'h5A)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .proc_start(proc_start),
        .proc_done (proc_done),
        .busy      (busy),
        .pkt_ok    (pkt_ok),
        .err       (err),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rxv;
        logic [7:0]  rxd;
        logic        done;
        logic        clr;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wd;
        logic        start;
        logic        ok;
        logic        busy;
        logic [2:0]  err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rxv, input logic [7:0] rxd, input logic done,
                                input logic clr, input logic we, input logic [15:0] addr,
                                input logic [7:0] wd, input logic start, input logic ok,
                                input logic bsy, input logic [2:0] e);
        vec_t v;
        v.rxv = rxv; v.rxd = rxd; v.done = done; v.clr = clr;
        v.we = we; v.addr = addr; v.wd = wd; v.start = start;
        v.ok = ok; v.busy = bsy; v.err = e;
        return v;
    endfunction

    // Plain byte with no write/pulse expected.
    function automatic vec_t pb(input logic [7:0] b, input logic bsy, input logic [2:0] e);
        return mk(1, b, 0, 0, 0, 16'h0, 8'h0, 0, 0, bsy, e);
    endfunction

    // Data byte expected to produce a write at address a.
    function automatic vec_t wr(input logic [7:0] b, input logic [15:0] a);
        return mk(1, b, 0, 0, 1, a, b, 0, 0, 1, 3'b000);
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then compare outputs just after the edge.
    task automatic apply(input vec_t v, input string nm);
        logic [30:0] a, e;
        rx_valid  = v.rxv;
        rx_data   = v.rxd;
        proc_done = v.done;
        clr_err   = v.clr;
        @(posedge clk);
        #1;
        e = {v.we, v.we ? v.addr : 16'h0, v.we ? v.wd : 8'h0, v.start, v.ok, v.busy, v.err};
        a = {mem_we, v.we ? mem_addr : 16'h0, v.we ? mem_wdata : 8'h0,
             proc_start, pkt_ok, busy, err};
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got we=%b addr=%h wd=%h start=%b ok=%b busy=%b err=%b, expected we=%b addr=%h wd=%h start=%b ok=%b busy=%b err=%b",
                     nm, mem_we, mem_addr, mem_wdata, proc_start, pkt_ok, busy, err,
                     v.we, v.addr, v.wd, v.start, v.ok, v.busy, v.err);
        end
        rx_valid  = 1'b0;
        proc_done = 1'b0;
        clr_err   = 1'b0;
    endtask

    function automatic vec_t idle(input logic bsy, input logic [2:0] e);
        return mk(0, 8'h00, 0, 0, 0, 16'h0, 8'h0, 0, 0, bsy, e);
    endfunction

    initial begin
        int cyc;
        int npulse;
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; proc_done = 1'b0; clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {mem_we, mem_addr, mem_wdata, proc_start, pkt_ok, busy, err}, 0);
        rst = 1'b0;

        // Good WRITE: checksum = 01^00^03^11^22^33 = 02
        tbl.push_back(pb(8'hA5, 1, 3'b000));
        tbl.push_back(pb(8'h01, 1, 3'b000));
        tbl.push_back(pb(8'h00, 1, 3'b000));
        tbl.push_back(pb(8'h03, 1, 3'b000));
        tbl.push_back(wr(8'h11, 16'h0100));
        tbl.push_back(wr(8'h22, 16'h0101));
        tbl.push_back(wr(8'h33, 16'h0102));
        tbl.push_back(mk(1, 8'h02, 0, 0, 0, 16'h0, 8'h0, 0, 1, 0, 3'b000));
        tbl.push_back(idle(0, 3'b000));
        // Same packet, wrong checksum
        tbl.push_back(pb(8'hA5, 1, 3'b000));
        tbl.push_back(pb(8'h01, 1, 3'b000));
        tbl.push_back(pb(8'h00, 1, 3'b000));
        tbl.push_back(pb(8'h03, 1, 3'b000));
        tbl.push_back(wr(8'h11, 16'h0100));
        tbl.push_back(wr(8'h22, 16'h0101));
        tbl.push_back(wr(8'h33, 16'h0102));
        tbl.push_back(pb(8'h00, 0, 3'b001));
        tbl.push_back(idle(0, 3'b001));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 16'h0, 8'h0, 0, 0, 0, 3'b000));
        // Address wrap: FF^FF^02^AA^BB = 13
        tbl.push_back(pb(8'hA5, 1, 3'b000));
        tbl.push_back(pb(8'hFF, 1, 3'b000));
        tbl.push_back(pb(8'hFF, 1, 3'b000));
        tbl.push_back(pb(8'h02, 1, 3'b000));
        tbl.push_back(wr(8'hAA, 16'hFFFF));
        tbl.push_back(wr(8'hBB, 16'h0000));
        tbl.push_back(mk(1, 8'h13, 0, 0, 0, 16'h0, 8'h0, 0, 1, 0, 3'b000));
        // RUN, stray byte while waiting, then done
        tbl.push_back(pb(8'h5A, 1, 3'b000));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 16'h0, 8'h0, 1, 0, 1, 3'b000));
        tbl.push_back(idle(1, 3'b000));
        tbl.push_back(pb(8'h33, 1, 3'b100));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 16'h0, 8'h0, 0, 0, 0, 3'b100));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 16'h0, 8'h0, 0, 0, 0, 3'b000));
        // Bad command; error set wins over simultaneous clear
        tbl.push_back(pb(8'h77, 0, 3'b100));
        tbl.push_back(mk(1, 8'h77, 0, 1, 0, 16'h0, 8'h0, 0, 0, 0, 3'b100));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 16'h0, 8'h0, 0, 0, 0, 3'b000));
        // proc_done while idle is ignored
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 16'h0, 8'h0, 0, 0, 0, 3'b000));
        // RUN with byte and done in the same cycle
        tbl.push_back(pb(8'h5A, 1, 3'b000));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 16'h0, 8'h0, 1, 0, 1, 3'b000));
        tbl.push_back(mk(1, 8'h44, 1, 0, 0, 16'h0, 8'h0, 0, 0, 0, 3'b100));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 16'h0, 8'h0, 0, 0, 0, 3'b000));

        foreach (tbl[i]) apply(tbl[i], $sformatf("tbl[%0d]", i));

        // 256-byte burst: header 20,00,00; data i; XOR of 0..255 is 0 so chk = 20
        apply(pb(8'hA5, 1, 3'b000), "b256_hdr");
        apply(pb(8'h20, 1, 3'b000), "b256_ahi");
        apply(pb(8'h00, 1, 3'b000), "b256_alo");
        apply(pb(8'h00, 1, 3'b000), "b256_len");
        npulse = 0;
        for (int i = 0; i < 256; i++) begin
            apply(wr(8'(i), 16'h2000 + 16'(i)), $sformatf("b256_data[%0d]", i));
            if (mem_we) npulse++;
        end
        check("b256_pulses", npulse, 256);
        apply(mk(1, 8'h20, 0, 0, 0, 16'h0, 8'h0, 0, 1, 0, 3'b000), "b256_chk");

        // Byte arriving exactly on the expiry cycle wins over the timeout
        apply(pb(8'hA5, 1, 3'b000), "tmo_hdr");
        for (int i = 0; i < TMO - 1; i++) apply(idle(1, 3'b000), "tmo_gap");
        apply(pb(8'h01, 1, 3'b000), "tmo_edge_byte");
        // Now let it expire: busy must drop after exactly TMO idle cycles
        cyc = 0;
        npulse = 0;
        while (busy && cyc < 3 * TMO) begin
            @(posedge clk);
            #1;
            cyc++;
            if (mem_we) npulse++;
        end
        check("tmo_latency", cyc, TMO);
        check("tmo_err", int'(err), 3'b010);
        check("tmo_no_write", npulse, 0);
        apply(mk(0, 8'h00, 0, 1, 0, 16'h0, 8'h0, 0, 0, 0, 3'b000), "tmo_clr");
        // Fresh packet after the timeout: 02^00^01^5C = 5F
        apply(pb(8'hA5, 1, 3'b000), "post_hdr");
        apply(pb(8'h02, 1, 3'b000), "post_ahi");
        apply(pb(8'h00, 1, 3'b000), "post_alo");
        apply(pb(8'h01, 1, 3'b000), "post_len");
        apply(wr(8'h5C, 16'h0200), "post_data");
        apply(mk(1, 8'h5F, 0, 0, 0, 16'h0, 8'h0, 0, 1, 0, 3'b000), "post_chk");

        // Reset mid-packet while a data byte is presented
        apply(pb(8'hA5, 1, 3'b000), "rst_hdr");
        apply(pb(8'h01, 1, 3'b000), "rst_ahi");
        apply(pb(8'h00, 1, 3'b000), "rst_alo");
        apply(pb(8'h02, 1, 3'b000), "rst_len");
        apply(wr(8'h11, 16'h0100), "rst_data0");
        rst = 1'b1;
        apply(pb(8'h22, 0, 3'b000), "rst_abort");
        rst = 1'b0;
        apply(idle(0, 3'b000), "rst_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
